// File: rtl/key_sched_pkg.sv
// Shared types and helpers for the sequential round-key scheduler.
// Holds the PRESENT S-box, the FSM state encoding and the index-width helper.
package key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM_F = 2'd1,
    FILL     = 2'd2,
    STREAM_R = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/key_step_unit.sv
// Combinational key-state step: rotate left, S-box the top nibble,
// then XOR the round counter into the field starting at RC_LSB.
module key_step_unit
  import key_sched_pkg::*;
#(
  parameter int KEY_W  = 20,
  parameter int ROT    = 7,
  parameter int RC_W   = 3,
  parameter int RC_LSB = 4
) (
  input  logic [KEY_W-1:0] s,
  input  logic [RC_W-1:0]  i,
  output logic [KEY_W-1:0] s_next
);

  logic [KEY_W-1:0] rot;
  logic [KEY_W-1:0] sub;
  logic [KEY_W-1:0] rc_field;

  assign rot      = (s << ROT) | (s >> (KEY_W - ROT));
  assign rc_field = KEY_W'(i) << RC_LSB;

  always_comb begin
    sub = rot;
    sub[KEY_W-1 -: 4] = present_sbox(rot[KEY_W-1 -: 4]);
  end

  assign s_next = sub ^ rc_field;

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential round-key generator: streams k0..k(N-1) for encrypt, or fills a
// buffer and streams k(N-1)..k0 for decrypt, over a valid/ready handshake.
module key_schedule_seq
  import key_sched_pkg::*;
#(
  parameter int KEY_W  = 20,
  parameter int RK_W   = 16,
  parameter int NUM_RK = 8,
  parameter int ROT    = 7,
  parameter int RC_W   = 3,
  parameter int RC_LSB = 4,
  localparam int IDX_W = idx_width(NUM_RK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             decrypt,
  input  logic [KEY_W-1:0] master_key,
  input  logic             abort,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  rk_data,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_last,
  output logic             busy,
  output logic             done
);

  // Handshake: a key transfers on a rising edge where rk_valid & rk_ready;
  // while rk_valid & !rk_ready, rk_data/rk_idx/rk_last are held unchanged.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] idx_dec;
  logic [KEY_W-1:0] key_s;
  logic [KEY_W-1:0] key_nxt;
  logic [RC_W-1:0]  rc;
  logic [RK_W-1:0]  rk_buf [NUM_RK];
  logic             hs;

  assign idx_inc = idx + IDX_W'(1);
  assign idx_dec = idx - IDX_W'(1);
  assign rc      = RC_W'(idx) + RC_W'(1);
  assign hs      = rk_valid & rk_ready;

  // One step unit shared by forward streaming and the decrypt fill pass.
  key_step_unit #(
    .KEY_W (KEY_W),
    .ROT   (ROT),
    .RC_W  (RC_W),
    .RC_LSB(RC_LSB)
  ) u_step (
    .s     (key_s),
    .i     (rc),
    .s_next(key_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      key_s    <= '0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int k = 0; k < NUM_RK; k++) rk_buf[k] <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        idx      <= '0;
        rk_valid <= 1'b0;
        rk_data  <= '0;
        rk_idx   <= '0;
        rk_last  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              key_s <= master_key;
              idx   <= '0;
              busy  <= 1'b1;
              if (decrypt) begin
                state <= FILL;
              end else begin
                state    <= STREAM_F;
                rk_valid <= 1'b1;
                rk_data  <= master_key[KEY_W-1 -: RK_W];
                rk_idx   <= '0;
                rk_last  <= 1'b0;
              end
            end
          end
          STREAM_F: begin
            if (hs) begin
              if (idx == LAST_IDX) begin
                state    <= IDLE;
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                key_s   <= key_nxt;
                idx     <= idx_inc;
                rk_data <= key_nxt[KEY_W-1 -: RK_W];
                rk_idx  <= idx_inc;
                rk_last <= (idx_inc == LAST_IDX);
              end
            end
          end
          FILL: begin
            rk_buf[idx] <= key_s[KEY_W-1 -: RK_W];
            key_s       <= key_nxt;
            if (idx == LAST_IDX) begin
              // The newest key is presented straight from the key state.
              state    <= STREAM_R;
              rk_valid <= 1'b1;
              rk_data  <= key_s[KEY_W-1 -: RK_W];
              rk_idx   <= LAST_IDX;
              rk_last  <= 1'b0;
            end else begin
              idx <= idx_inc;
            end
          end
          STREAM_R: begin
            if (hs) begin
              if (idx == '0) begin
                state    <= IDLE;
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                idx     <= idx_dec;
                rk_data <= rk_buf[idx_dec];
                rk_idx  <= idx_dec;
                rk_last <= (idx_dec == '0);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq: encrypt/decrypt streams, backpressure,
// abort with a simultaneous handshake, and async reset in the middle of a fill.
module tb_key_schedule_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [19:0] master_key = '0;
  logic        abort = 1'b0;
  logic        rk_ready = 1'b0;
  logic        rk_valid;
  logic [15:0] rk_data;
  logic [2:0]  rk_idx;
  logic        rk_last;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [15:0] mk_keys [8];
  logic [15:0] exp_q [$];
  int          exp_i [$];

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  key_schedule_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .decrypt   (decrypt),
    .master_key(master_key),
    .abort     (abort),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Reference step: rotate one bit at a time, substitute top nibble, add counter.
  function automatic logic [19:0] m_step(input logic [19:0] s, input int i);
    logic [19:0] t;
    t = s;
    for (int k = 0; k < 7; k++) t = {t[18:0], t[19]};
    t[19:16] = SBOX[t[19:16]];
    t = t ^ 20'((i % 8) * 16);
    return t;
  endfunction

  task automatic build(input logic [19:0] mk);
    logic [19:0] s;
    s = mk;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) s = m_step(s, i);
      mk_keys[i] = s[19:4];
    end
  endtask

  // Called at a falling edge; returns one falling edge later with start dropped.
  task automatic start_sched(input logic [19:0] mk, input logic dec);
    master_key = mk;
    decrypt    = dec;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expects the first encrypt key to be on the outputs and rk_ready = 1.
  task automatic run_enc_full(input string pfx);
    for (int i = 0; i < 8; i++) begin
      chk({pfx, "_valid"}, 32'(rk_valid), 32'd1);
      chk({pfx, "_data"}, 32'(rk_data), 32'(mk_keys[i]));
      chk({pfx, "_idx"}, 32'(rk_idx), 32'(i));
      chk({pfx, "_last"}, 32'(rk_last), (i == 7) ? 32'd1 : 32'd0);
      chk({pfx, "_nodone"}, 32'(done), 32'd0);
      @(negedge clk);
    end
    chk({pfx, "_done"}, 32'(done), 32'd1);
    chk({pfx, "_valid_end"}, 32'(rk_valid), 32'd0);
    chk({pfx, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic run_bp(input logic [19:0] mk, input logic dec, input string pfx);
    logic        held;
    logic [15:0] hd;
    logic [2:0]  hi;
    bit          seen_done;
    held = 1'b0;
    hd = '0;
    hi = '0;
    seen_done = 1'b0;
    build(mk);
    exp_q.delete();
    exp_i.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(dec ? mk_keys[7-i] : mk_keys[i]);
      exp_i.push_back(dec ? 7 - i : i);
    end
    rk_ready = 1'b0;
    start_sched(mk, dec);
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (held) begin
        chk({pfx, "_hold_valid"}, 32'(rk_valid), 32'd1);
        chk({pfx, "_hold_data"}, 32'(rk_data), 32'(hd));
        chk({pfx, "_hold_idx"}, 32'(rk_idx), 32'(hi));
      end
      if (done) begin
        seen_done = 1'b1;
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            chk({pfx, "_extra_key"}, 32'(rk_data), 32'hFFFF_FFFF);
          end else begin
            chk({pfx, "_sb_data"}, 32'(rk_data), 32'(exp_q.pop_front()));
            chk({pfx, "_sb_idx"}, 32'(rk_idx), 32'(exp_i.pop_front()));
          end
          held = 1'b0;
        end else if (rk_valid) begin
          held = 1'b1;
          hd = rk_data;
          hi = rk_idx;
        end else begin
          held = 1'b0;
        end
        @(negedge clk);
      end
    end
    chk({pfx, "_done_seen"}, 32'(seen_done), 32'd1);
    chk({pfx, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    rk_ready = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rk_valid), 32'd0);
    chk("rst_data", 32'(rk_data), 32'd0);
    chk("rst_idx", 32'(rk_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: encrypt 0xABCDE, no backpressure
    rk_ready = 1'b1;
    build(20'hABCDE);
    chk("t1_model_k1", 32'(mk_keys[1]), 32'h16F4);
    start_sched(20'hABCDE, 1'b0);
    chk("t1_k0", 32'(rk_data), 32'hABCD);
    chk("t1_busy", 32'(busy), 32'd1);
    run_enc_full("t1");
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // 2: encrypt zero key, then restart in the cycle done is high
    start_sched(20'h00000, 1'b0);
    chk("t2_k0", 32'(rk_data), 32'h0000);
    @(negedge clk);
    chk("t2_k1", 32'(rk_data), 32'hC001);
    chk("t2_idx1", 32'(rk_idx), 32'd1);
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    build(20'hABCDE);
    start_sched(20'hABCDE, 1'b0);
    run_enc_full("t2_restart");
    @(negedge clk);

    // 3: decrypt 0xABCDE
    start_sched(20'hABCDE, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk("t3_fill_valid", 32'(rk_valid), 32'd0);
      chk("t3_fill_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    for (int j = 7; j >= 0; j--) begin
      chk("t3_valid", 32'(rk_valid), 32'd1);
      chk("t3_data", 32'(rk_data), 32'(mk_keys[j]));
      chk("t3_idx", 32'(rk_idx), 32'(j));
      chk("t3_last", 32'(rk_last), (j == 0) ? 32'd1 : 32'd0);
      if (j == 1) chk("t3_k1", 32'(rk_data), 32'h16F4);
      if (j == 0) chk("t3_k0", 32'(rk_data), 32'hABCD);
      @(negedge clk);
    end
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'd0);
    @(negedge clk);

    // 4: random backpressure, both modes
    run_bp(20'h5A3C1, 1'b0, "t4e");
    @(negedge clk);
    run_bp(20'hF0E17, 1'b1, "t4d");
    @(negedge clk);

    // 5: abort at idx 3 together with a handshake
    build(20'hABCDE);
    start_sched(20'hABCDE, 1'b0);
    chk("t5_idx0", 32'(rk_idx), 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_idx3", 32'(rk_idx), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_valid", 32'(rk_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_nodone", 32'(done), 32'd0);
    @(negedge clk);
    chk("t5_nodone2", 32'(done), 32'd0);
    start_sched(20'hABCDE, 1'b0);
    chk("t5_k0", 32'(rk_data), 32'hABCD);
    chk("t5_k0_idx", 32'(rk_idx), 32'd0);
    @(negedge clk);
    chk("t5_k1", 32'(rk_data), 32'h16F4);
    for (int c = 0; c < 20 && !done; c++) @(negedge clk);
    @(negedge clk);

    // 6: start ignored while busy, then async reset mid-fill
    start_sched(20'hABCDE, 1'b1);
    repeat (2) @(negedge clk);
    decrypt = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_busy_fill", 32'(busy), 32'd1);
    chk("t6_valid_fill", 32'(rk_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rk_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_idx", 32'(rk_idx), 32'd0);
    chk("t6_rst_data", 32'(rk_data), 32'd0);
    chk("t6_rst_last", 32'(rk_last), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_valid", 32'(rk_valid), 32'd0);
    build(20'h12345);
    start_sched(20'h12345, 1'b0);
    run_enc_full("t6");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
